// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension unit: one shift-add or restoring-divide step per cycle.
// Operands are reduced to magnitudes on accept; the sign is reapplied in FIX.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_tag_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   b_reg;
  logic [2:0]        op_reg;
  logic              neg_reg;
  logic [XLEN-1:0]   result_reg;
  logic [4:0]        tag_reg;
  logic              out_valid_reg;

  logic            accept, a_signed, b_signed, sa, sb, special;
  logic [XLEN-1:0] mag_a, mag_b, special_result, fix_result;
  logic [2*XLEN-1:0] step_next, prod_signed;
  logic [XLEN:0]     mul_sum, rem_shift;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN-1:0]   quo_signed, rem_signed;

  assign in_ready_o  = (state_reg == IDLE);
  assign busy_o      = (state_reg != IDLE);
  assign out_valid_o = out_valid_reg;
  assign result_o    = result_reg;
  assign rd_tag_o    = tag_reg;

  assign accept   = in_valid_i && in_ready_o && !flush_i;
  assign a_signed = (op_i[2:0] == 3'b001) || (op_i[2:0] == 3'b010) || (op_i[2] && !op_i[0]);
  assign b_signed = (op_i[2:0] == 3'b001) || (op_i[2] && !op_i[0]);
  assign sa       = a_signed && rs1_i[XLEN-1];
  assign sb       = b_signed && rs2_i[XLEN-1];
  assign mag_a    = sa ? -rs1_i : rs1_i;
  assign mag_b    = sb ? -rs2_i : rs2_i;

  // Ops that resolve without iterating: non-M codes, divide by zero, signed overflow
  always_comb begin
    special        = 1'b0;
    special_result = '0;
    if (op_i[4:3] != 2'b01) begin
      special = 1'b1;
    end else if (op_i[2] && (rs2_i == '0)) begin
      special        = 1'b1;
      special_result = op_i[1] ? rs1_i : '1;
    end else if (op_i[2] && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1)) begin
      special        = 1'b1;
      special_result = op_i[1] ? '0 : MIN_NEG;
    end
  end

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
    rem_shift = acc_reg[2*XLEN-1:XLEN-1];
    div_diff  = {1'b0, rem_shift} - {2'b00, b_reg};
    if (!op_reg[2])
      step_next = {mul_sum, acc_reg[XLEN-1:1]};
    else if (div_diff[XLEN+1])
      step_next = {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    else
      step_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod_signed = neg_reg ? -acc_reg : acc_reg;
    quo_signed  = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_signed  = neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    case (op_reg)
      3'b000:         fix_result = prod_signed[XLEN-1:0];
      3'b100, 3'b101: fix_result = quo_signed;
      3'b110, 3'b111: fix_result = rem_signed;
      default:        fix_result = prod_signed[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (count_reg == CW'(XLEN-1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_valid_reg && out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      acc_reg       <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      neg_reg       <= 1'b0;
      result_reg    <= '0;
      tag_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else if (flush_i) begin
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          op_reg    <= op_i[2:0];
          tag_reg   <= rd_tag_i;
          count_reg <= '0;
          acc_reg   <= {{XLEN{1'b0}}, mag_a};
          b_reg     <= mag_b;
          neg_reg   <= (op_i[2:1] == 2'b11) ? sa : (sa ^ sb);
          if (special) result_reg <= special_result;
        end
        CALC: begin
          acc_reg   <= step_next;
          count_reg <= count_reg + CW'(1);
        end
        FIX: begin
          result_reg    <= fix_result;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          // Special ops enter DONE with valid low; it rises one cycle later
          if (out_valid_reg && out_ready_i) out_valid_reg <= 1'b0;
          else                              out_valid_reg <= 1'b1;
        end
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a plain-arithmetic model.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [4:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  rd_tag_o;
  logic        busy_o;

  int total = 0;
  int bad = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_tag_i(rd_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .rd_tag_o(rd_tag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (op[4:3] != 2'b01) return 32'h0;
    case (op[2:0])
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4:3] != 2'b01) return 1;
    if (op[2] && b == 0) return 1;
    if (op[2] && !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    @(negedge clk);
    check("in_ready_before_send", 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_tag_i = tag;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; op_i = 5'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int lat;
    logic [31:0] exp;
    exp = model(op, a, b);
    send(op, a, b, tag);
    wait_out(lat);
    $display("op=%b a=%h b=%h result=%h expect=%h tag=%0d lat=%0d", op, a, b, result_o, exp, rd_tag_o, lat);
    check("latency", 32'(lat), 32'(latency(op, a, b)));
    check("result", result_o, exp);
    check("tag", 32'(rd_tag_o), 32'(tag));
    @(posedge clk);
    #1;
    check("valid_drop", 32'(out_valid_o), 32'd0);
    check("ready_back", 32'(in_ready_o), 32'd1);
  endtask

  logic [4:0]  dir_op [12] = '{5'b01000, 5'b01011, 5'b01001, 5'b01010, 5'b01100, 5'b01110,
                                5'b01101, 5'b01111, 5'b01100, 5'b01111, 5'b01100, 5'b01110};
  logic [31:0] dir_a  [12] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'd100, 32'd100, 32'h55, 32'h1234, 32'h80000000, 32'h80000000};
  logic [31:0] dir_b  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};

  initial begin
    int lat;
    logic seen;
    logic [31:0] exp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready_o), 32'd1);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_tag", 32'(rd_tag_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run(dir_op[i], dir_a[i], dir_b[i], 5'(i + 5));

    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      op = {2'b01, 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 9) == 0) op = 5'($urandom);
      run(op, pick(), pick(), 5'($urandom));
    end

    // Backpressure
    out_ready_i = 1'b0;
    exp = model(5'b01011, 32'hDEADBEEF, 32'h12345678);
    send(5'b01011, 32'hDEADBEEF, 32'h12345678, 5'd9);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1; op_i = 5'b01000; rs1_i = $urandom; rs2_i = $urandom;
      @(posedge clk);
      #1;
      check("bp_result", result_o, exp);
      check("bp_tag", 32'(rd_tag_o), 32'd9);
      check("bp_valid", 32'(out_valid_o), 32'd1);
      check("bp_ready", 32'(in_ready_o), 32'd0);
    end
    $display("backpressure result=%h tag=%0d", result_o, rd_tag_o);
    @(negedge clk);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid_o), 32'd0);
    check("bp_release_ready", 32'(in_ready_o), 32'd1);

    // Flush mid-CALC
    send(5'b01000, 32'd123, 32'd456, 5'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_ready", 32'(in_ready_o), 32'd1);
    check("flush_busy", 32'(busy_o), 32'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid_o) seen = 1'b1; end
    check("flush_no_result", 32'(seen), 32'd0);
    $display("flush mid-calc: result suppressed=%0d", !seen);
    run(5'b01000, 32'd3, 32'd4, 5'd12);

    // Flush concurrent with a request in IDLE
    @(negedge clk);
    in_valid_i = 1'b1; flush_i = 1'b1; op_i = 5'b01101; rs1_i = 32'd50; rs2_i = 32'd5; rd_tag_i = 5'd7;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_busy", 32'(busy_o), 32'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid_o) seen = 1'b1; end
    check("flush_idle_dropped", 32'(seen), 32'd0);
    $display("flush in idle: request dropped=%0d", !seen);

    // Asynchronous reset mid-CALC
    send(5'b01101, 32'hFFFF0000, 32'd3, 5'd21);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(in_ready_o), 32'd1);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_valid", 32'(out_valid_o), 32'd0);
    check("arst_result", result_o, 32'd0);
    check("arst_tag", 32'(rd_tag_o), 32'd0);
    $display("async reset: busy=%0d result=%h", busy_o, result_o);
    @(negedge clk);
    rst_n = 1'b1;
    run(5'b01101, 32'd9, 32'd3, 5'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative sequencer for the RV32 M-extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the integer ALU in execute. The decoder steers R-type ops whose func code selects M-extension here.
- Uses a valid/ready handshake on input and output.
- Runs one shift-add or restoring-divide step per cycle and carries the destination register tag through to the result.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; abort current op
in_valid_i  in  1  operation request
in_ready_o  in/out: out  1  unit can accept request
op_i  in  5  func code {instr[30],instr[25],instr[14:12]}: MUL 01000, MULH 01001, MULHSU 01010, MULHU 01011, DIV 01100, DIVU 01101, REM 01110, REMU 01111
rs1_i  in  XLEN  operand A (multiplicand/dividend)
rs2_i  in  XLEN  operand B (multiplier/divisor)
rd_tag_i  in  5  destination register index
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
result_o  out  XLEN  result
rd_tag_o  out  5  tag of result
busy_o  out  1  state != IDLE

Behaviour:
Clock and reset:
- One clock, clk.
- rst_n is asynchronous and active-low.
- Reset values: state IDLE, out_valid_o 0, result_o 0, rd_tag_o 0, busy_o 0, iteration counter 0, all datapath registers 0.
- in_ready_o is combinational (state==IDLE), so it reads 1 in and after reset.

FSM states are IDLE, CALC, FIX, DONE.
- IDLE: an accept occurs when in_valid_i and in_ready_o are both high. On accept, latch op, tag and operands.
  - Special case, op_i[4:3] != 01: go to DONE with result 0.
  - Special case, divide/remainder with rs2==0: go to DONE. Quotient is all ones (DIV, DIVU). Remainder is rs1 (REM, REMU).
  - Special case, signed overflow with rs1==0x80000000 and rs2==0xFFFFFFFF (DIV/REM only): go to DONE. DIV gives 0x80000000; REM gives 0.
  - Otherwise go to CALC with counter 0. Operands are replaced by magnitudes where the op treats them as signed:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: rs1 signed only.
  - Record result sign:
    - Products and quotients: sa^sb.
    - Remainders: sa.
- CALC: one step per cycle; the counter increments each cycle. After XLEN steps (counter==XLEN-1) go to FIX.
  - Multiply: 2*XLEN-bit accumulator, shift-add on LSB of multiplier.
  - Divide: restoring division with 2*XLEN-bit shift register, one quotient bit per step.
- FIX: apply two's-complement negation if the sign flag is set. Select low/high product half, quotient or remainder into result_o. Set out_valid_o and go to DONE.
- DONE: hold result_o, rd_tag_o and out_valid_o stable until out_ready_i is high. On handshake, go to IDLE with out_valid_o 0.
  - in_ready_o is low in DONE, so there is no same-cycle accept; back-to-back throughput is one op per XLEN+3 cycles minimum.

Latency, accept at edge N:
- Normal ops: out_valid_o rises after edge N+XLEN+1 (33 edges for XLEN=32).
- Special cases: out_valid_o rises after edge N+1.

Flush and reset:
- flush_i has highest priority. At the next edge, state goes to IDLE and out_valid_o goes to 0. No result is produced, including for a request offered the same cycle (it is dropped).
- Flush in IDLE has no effect.
- Async reset mid-operation returns immediately to reset values. No partial result is emitted.

Width and stability:
- All arithmetic is unsigned on magnitudes.
- Magnitude of 0x80000000 is 0x80000000 unsigned, which is correct.
- Operand inputs are don't-care after accept.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD, tag 5 -> result 0xFFFFFFEB, rd_tag_o 5, out_valid_o rises exactly 33 edges after accept; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
2. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
3. DIV x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Each with out_valid_o one edge after accept.
4. Backpressure: hold out_ready_i low 10 cycles after out_valid_o -> result_o/rd_tag_o stable, in_ready_o low, in_valid_i ignored; release -> IDLE next edge, in_ready_o 1.
5. Flush at CALC iteration 10 -> out_valid_o never asserts, in_ready_o 1 next cycle; new MUL 3*4 then returns 12. Flush concurrent with in_valid_i in IDLE -> request dropped.
6. Deassert rst_n asynchronously mid-CALC -> outputs immediately at reset values; after release a DIVU 9/3 returns 3.
